data_mem_burst_slave: RTL

Burst-capable data memory on the `sys_clk` side of the chip. It serves the CPU data path's cache refill and writeback traffic. The block accepts one request at a time: either a read burst of `READ_BURST_LEN` words or a write burst of `WRITE_BURST_LEN` words. Read data streams out and write data streams in over valid/ready channels, and every write burst is closed with a response beat. Storage is an internal array of `NUM_WORDS_DATA_MEM` words.

---
 rtl/data_mem_burst_slave_if.sv | 48 ++++
 rtl/data_mem_burst_slave.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_burst_slave_if.sv
// Request / read-data / write-data / write-response channels of the burst data memory.
// The slave modport is the memory side; the master modport is the requester.
interface data_mem_burst_slave_if #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned DATA_ADDR_WIDTH = 32
);
    logic                       req_valid;
    logic                       req_ready;
    logic                       req_write;
    logic [DATA_ADDR_WIDTH-1:0] req_addr;

    logic                       rdata_valid;
    logic                       rdata_ready;
    logic [DATA_WIDTH-1:0]      rdata;
    logic                       rdata_last;
    logic                       rdata_err;

    logic                       wdata_valid;
    logic                       wdata_ready;
    logic [DATA_WIDTH-1:0]      wdata;
    logic                       wdata_last;

    logic                       wresp_valid;
    logic                       wresp_ready;
    logic                       wresp_err;

    modport slave (
        input  req_valid, req_write, req_addr,
        input  rdata_ready,
        input  wdata_valid, wdata, wdata_last,
        input  wresp_ready,
        output req_ready,
        output rdata_valid, rdata, rdata_last, rdata_err,
        output wdata_ready,
        output wresp_valid, wresp_err
    );

    modport master (
        output req_valid, req_write, req_addr,
        output rdata_ready,
        output wdata_valid, wdata, wdata_last,
        output wresp_ready,
        input  req_ready,
        input  rdata_valid, rdata, rdata_last, rdata_err,
        input  wdata_ready,
        input  wresp_valid, wresp_err
    );
endinterface

// File: rtl/data_mem_burst_slave.sv
// Burst data memory: one read or write burst at a time over valid/ready channels.
// Define DATA_MEM_BOUNDS_CHECK_EN to flag bursts that run past the end of storage.
module data_mem_burst_slave #(
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned DATA_ADDR_WIDTH    = 32,
    parameter int unsigned NUM_WORDS_DATA_MEM = 128,
    parameter int unsigned READ_BURST_LEN     = 8,
    parameter int unsigned WRITE_BURST_LEN    = 8
) (
    input logic                  sys_clk,
    input logic                  sys_rst,
    data_mem_burst_slave_if.slave bus
);

    localparam int unsigned IDX_W   = $clog2(NUM_WORDS_DATA_MEM);
    localparam int unsigned MAX_LEN = (READ_BURST_LEN > WRITE_BURST_LEN) ?
                                      READ_BURST_LEN : WRITE_BURST_LEN;
    localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_BURST_LEN - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_BURST_LEN - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StWresp
    } state_e;

    state_e                 state_q;
    logic [IDX_W-1:0]       idx_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   oob_q;
    logic                   sticky_q;

    logic                   req_ready_q;
    logic                   rdata_valid_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic                   rdata_last_q;
    logic                   rdata_err_q;
    logic                   wdata_ready_q;
    logic                   wresp_valid_q;
    logic                   wresp_err_q;

    logic [DATA_WIDTH-1:0]  mem [NUM_WORDS_DATA_MEM];

    logic [IDX_W-1:0]       start_idx;
    logic [IDX_W-1:0]       idx_nxt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic                   req_fire;
    logic                   wr_fire;
    logic                   last_mismatch;
    logic                   mem_we;
    logic                   oob_rd;
    logic                   oob_wr;
    logic                   unused_addr;

    assign start_idx = bus.req_addr[IDX_W+1:2];
    assign idx_nxt   = idx_q + 1'b1;
    assign cnt_nxt   = cnt_q + 1'b1;

    // Byte-lane bits and address bits above the storage range do not select a word.
    assign unused_addr = ^{bus.req_addr[DATA_ADDR_WIDTH-1:IDX_W+2], bus.req_addr[1:0]};

`ifdef DATA_MEM_BOUNDS_CHECK_EN
    logic [31:0] start_ext;
    assign start_ext = 32'(start_idx);
    assign oob_rd    = (start_ext + READ_BURST_LEN) > NUM_WORDS_DATA_MEM;
    assign oob_wr    = (start_ext + WRITE_BURST_LEN) > NUM_WORDS_DATA_MEM;
`else
    assign oob_rd = 1'b0;
    assign oob_wr = 1'b0;
`endif

    assign req_fire      = bus.req_valid && req_ready_q;
    assign wr_fire       = (state_q == StWr) && bus.wdata_valid && wdata_ready_q;
    // The beat counter decides where the burst ends; wdata_last is only cross-checked.
    assign last_mismatch = bus.wdata_last != (cnt_q == WR_LAST);
    assign mem_we        = wr_fire && !oob_q && !sys_rst;

    always_ff @(posedge sys_clk) begin
        if (mem_we) begin
            mem[idx_q] <= bus.wdata;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            cnt_q         <= '0;
            oob_q         <= 1'b0;
            sticky_q      <= 1'b0;
            req_ready_q   <= 1'b0;
            rdata_valid_q <= 1'b0;
            rdata_q       <= '0;
            rdata_last_q  <= 1'b0;
            rdata_err_q   <= 1'b0;
            wdata_ready_q <= 1'b0;
            wresp_valid_q <= 1'b0;
            wresp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    req_ready_q <= 1'b1;
                    if (req_fire) begin
                        req_ready_q <= 1'b0;
                        idx_q       <= start_idx;
                        cnt_q       <= '0;
                        if (bus.req_write) begin
                            oob_q         <= oob_wr;
                            wdata_ready_q <= 1'b1;
                            state_q       <= StWr;
                        end else begin
                            // First beat is fetched at acceptance so it is valid next cycle.
                            oob_q         <= oob_rd;
                            rdata_valid_q <= 1'b1;
                            rdata_q       <= oob_rd ? '0 : mem[start_idx];
                            rdata_last_q  <= (RD_LAST == '0);
                            rdata_err_q   <= oob_rd;
                            state_q       <= StRd;
                        end
                    end
                end

                StRd: begin
                    if (bus.rdata_ready) begin
                        if (cnt_q == RD_LAST) begin
                            rdata_valid_q <= 1'b0;
                            rdata_q       <= '0;
                            rdata_last_q  <= 1'b0;
                            rdata_err_q   <= 1'b0;
                            req_ready_q   <= 1'b1;
                            state_q       <= StIdle;
                        end else begin
                            idx_q        <= idx_nxt;
                            cnt_q        <= cnt_nxt;
                            rdata_q      <= oob_q ? '0 : mem[idx_nxt];
                            rdata_last_q <= (cnt_nxt == RD_LAST);
                        end
                    end
                end

                StWr: begin
                    if (wr_fire) begin
                        if (last_mismatch) begin
                            sticky_q <= 1'b1;
                        end
                        if (cnt_q == WR_LAST) begin
                            wdata_ready_q <= 1'b0;
                            wresp_valid_q <= 1'b1;
                            wresp_err_q   <= sticky_q || last_mismatch || oob_q;
                            state_q       <= StWresp;
                        end else begin
                            idx_q <= idx_nxt;
                            cnt_q <= cnt_nxt;
                        end
                    end
                end

                StWresp: begin
                    if (bus.wresp_ready) begin
                        wresp_valid_q <= 1'b0;
                        wresp_err_q   <= 1'b0;
                        sticky_q      <= 1'b0;
                        oob_q         <= 1'b0;
                        req_ready_q   <= 1'b1;
                        state_q       <= StIdle;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_last  = rdata_last_q;
    assign bus.rdata_err   = rdata_err_q;
    assign bus.wdata_ready = wdata_ready_q;
    assign bus.wresp_valid = wresp_valid_q;
    assign bus.wresp_err   = wresp_err_q;

endmodule
